axi_stream_header_scheduler: RTL
================================

Name: axi_stream_header_scheduler

Overview:
- Shares the single header-insert port of the AXI-Stream header inserter between NUM_REQ header sources.
- Round-robin arbitration; the grant is locked per packet.
- Offers exactly one header to the inserter, then blocks further headers until the inserter's output shows the packet's last-beat handshake.
- Sits between the per-channel header generators and the inserter's valid_insert/data_insert/keep_insert/byte_insert_cnt/ready_insert port. It taps the inserter's output handshake.

Parameters:
- NUM_REQ, 4, number of header requesters (2..16)
- DATA_WD, 32, header data width in bits
- DATA_BYTE_WD, DATA_WD/8, keep width
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte-count width
- REQ_ID_WD, $clog2(NUM_REQ), grant index width
- PKT_CNT_WD, 8, completed-packet counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester header valid
- req_data  in  NUM_REQ*DATA_WD  packed headers; requester i at slice [i*DATA_WD +: DATA_WD]
- req_keep  in  NUM_REQ*DATA_BYTE_WD  packed keeps
- req_byte_cnt  in  NUM_REQ*BYTE_CNT_WD  packed byte counts
- req_ready  out  NUM_REQ  one-hot capture strobe to the granted requester
- hdr_valid  out  1  header valid to inserter
- hdr_data  out  DATA_WD  header data to inserter
- hdr_keep  out  DATA_BYTE_WD  header keep to inserter
- hdr_byte_cnt  out  BYTE_CNT_WD  byte_insert_cnt to inserter
- hdr_ready  in  1  ready_insert from inserter
- mon_valid  in  1  inserter valid_out (tap)
- mon_ready  in  1  downstream ready_out (tap)
- mon_last  in  1  inserter last_out (tap)
- grant_id  out  REQ_ID_WD  index of current/last granted requester
- busy  out  1  high while not IDLE
- pkt_cnt  out  PKT_CNT_WD  completed packets, wraps

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - all outputs 0
  - state IDLE
  - rr pointer last_grant = NUM_REQ-1, so requester 0 has first priority
  - header holding registers 0
- States: IDLE, OFFER, WAIT_EOP.
- IDLE:
  - If any req_valid is high, select the first requester at or after (last_grant+1) mod NUM_REQ, scanning upward with wrap.
  - req_ready[sel] is asserted combinationally in the same cycle, which is the capture handshake.
  - Register that requester's data/keep/byte_cnt into the holding registers, set last_grant and grant_id to sel, go to OFFER.
  - If no req_valid is high, stay in IDLE; req_ready is all 0.
- OFFER:
  - hdr_valid=1; hdr_* are driven from the holding registers and held stable until hdr_ready.
  - On hdr_valid&&hdr_ready, go to WAIT_EOP; hdr_valid drops in the next cycle.
  - req_ready is 0 throughout.
- WAIT_EOP:
  - hdr_valid=0, req_ready=0.
  - On mon_valid&&mon_ready&&mon_last: pkt_cnt increments (wraps 2^PKT_CNT_WD-1 -> 0), go to IDLE.
- Latency:
  - req handshake -> hdr_valid: 1 cycle.
  - EOP handshake -> next req_ready: 1 cycle (IDLE arbitrates in the cycle after EOP). This gives 1 bubble cycle between packets.
- mon_last handshakes seen in IDLE or OFFER are ignored (no count, no state change).
- busy is combinational: (state != IDLE).
- Requesters obey AXI rules (valid held until ready). A requester whose valid is not selected sees req_ready=0 and keeps its valid.
- Reset asserted mid-OFFER or mid-WAIT_EOP returns to IDLE asynchronously:
  - hdr_valid drops immediately.
  - rr pointer returns to NUM_REQ-1.
  - pkt_cnt clears.
- byte_cnt is passed unmodified. No width arithmetic is applied except the modulo-NUM_REQ pointer increment; for non-power-of-two NUM_REQ, wrap explicitly at NUM_REQ-1.

Decomposition:
- Shared package axi_hdr_pkg:
  - state encoding (IDLE=2'd0, OFFER=2'd1, WAIT_EOP=2'd2)
  - width helper constants for DATA_BYTE_WD/BYTE_CNT_WD
- One sub-module: rr_arbiter.
  - Combinational, parameter NUM_REQ.
  - Inputs: req vector, last_grant. Outputs: one-hot grant, grant index, any_req.
  - Instantiated once. The top level owns the pointer register, FSM, holding registers and counter.

Test Plan:
- Reset: drive req_valid=4'b1111 during rst_n=0 -> req_ready=0, hdr_valid=0, pkt_cnt=0, busy=0. After release, the first grant is requester 0.
- Single requester: req_valid[2]=1 with data 32'hAABBCCDD, keep 4'b0111, byte_cnt 2 -> req_ready[2] pulses 1 cycle. Next cycle hdr_valid=1, hdr_data=32'hAABBCCDD, hdr_keep=4'b0111, hdr_byte_cnt=2, grant_id=2.
- Round robin: req_valid=4'b1011 held, each packet ended by one mon_last handshake -> grant order 0,1,3,0,1. Requester 2 is never granted.
- Backpressure: hold hdr_ready=0 for 5 cycles in OFFER -> hdr_* stable and hdr_valid=1 for all 5 cycles. After hdr_ready=1, one handshake, then WAIT_EOP.
- Lock and edge cases:
  - A mon_last handshake in OFFER is ignored; pkt_cnt is unchanged.
  - In WAIT_EOP with req_valid=4'b0100 pending, the EOP cycle gives no req_ready. req_ready[2] fires exactly 1 cycle after EOP, and pkt_cnt goes +1.
- Reset and counter wrap:
  - Assert rst_n=0 mid-WAIT_EOP -> state IDLE, busy=0 immediately.
  - Run 256 packets with PKT_CNT_WD=8 -> pkt_cnt wraps 255 -> 0.

Source files
------------

// File: rtl/axi_stream_header_scheduler_pkg.sv
// Shared definitions for the AXI-Stream header scheduler: FSM encoding and
// width helpers used to derive the keep and byte-count widths.
package axi_hdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OFFER    = 2'd1,
        ST_WAIT_EOP = 2'd2
    } hdr_state_e;

    localparam int DEF_DATA_WD = 32;

    // Number of keep bits for a given header data width.
    function automatic int byte_wd(input int data_wd);
        return data_wd / 8;
    endfunction

    // Byte-count width; never narrower than one bit so ports stay legal.
    function automatic int cnt_wd(input int byte_w);
        return (byte_w > 1) ? $clog2(byte_w) : 1;
    endfunction

endpackage

// File: rtl/axi_stream_header_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request at or
// after (last_grant + 1), wrapping at NUM_REQ-1 (works for any NUM_REQ).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_WD   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_WD-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_WD-1:0]   grant_idx,
    output logic               any_req
);

    // Scan candidates in rotating priority order and keep the first hit.
    always_comb begin
        logic [ID_WD:0]   sum_v;
        logic [ID_WD-1:0] cand_v;
        logic             found_v;
        logic             hit_v;
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        found_v   = 1'b0;
        sum_v     = '0;
        cand_v    = '0;
        hit_v     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum_v  = {1'b0, last_grant} + (ID_WD+1)'(k + 1);
            sum_v  = (sum_v >= (ID_WD+1)'(NUM_REQ)) ? (sum_v - (ID_WD+1)'(NUM_REQ)) : sum_v;
            cand_v = sum_v[ID_WD-1:0];
            hit_v  = ~found_v & req[cand_v];
            grant[cand_v] = grant[cand_v] | hit_v;
            grant_idx     = hit_v ? cand_v : grant_idx;
            found_v       = found_v | hit_v;
        end
    end

endmodule

// File: rtl/axi_stream_header_scheduler.sv
// Shares the inserter's single header port among NUM_REQ header sources.
// One header per packet is offered; the grant stays locked until the
// inserter output shows the last-beat handshake of that packet.
module axi_stream_header_scheduler
    import axi_hdr_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WD      = DEF_DATA_WD,
    parameter int DATA_BYTE_WD = byte_wd(DATA_WD),
    parameter int BYTE_CNT_WD  = cnt_wd(DATA_BYTE_WD),
    parameter int REQ_ID_WD    = $clog2(NUM_REQ),
    parameter int PKT_CNT_WD   = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0]        req_data,
    input  logic [NUM_REQ*DATA_BYTE_WD-1:0]   req_keep,
    input  logic [NUM_REQ*BYTE_CNT_WD-1:0]    req_byte_cnt,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              hdr_valid,
    output logic [DATA_WD-1:0]                hdr_data,
    output logic [DATA_BYTE_WD-1:0]           hdr_keep,
    output logic [BYTE_CNT_WD-1:0]            hdr_byte_cnt,
    input  logic                              hdr_ready,
    input  logic                              mon_valid,
    input  logic                              mon_ready,
    input  logic                              mon_last,
    output logic [REQ_ID_WD-1:0]              grant_id,
    output logic                              busy,
    output logic [PKT_CNT_WD-1:0]             pkt_cnt
);

    hdr_state_e                state_r;
    hdr_state_e                state_nxt_s;
    logic [REQ_ID_WD-1:0]      last_grant_r;
    logic [REQ_ID_WD-1:0]      grant_id_r;
    logic [REQ_ID_WD-1:0]      arb_idx_s;
    logic [NUM_REQ-1:0]        arb_grant_s;
    logic                      any_req_s;
    logic [DATA_WD-1:0]        hold_data_r;
    logic [DATA_BYTE_WD-1:0]   hold_keep_r;
    logic [BYTE_CNT_WD-1:0]    hold_cnt_r;
    logic [PKT_CNT_WD-1:0]     pkt_cnt_r;
    logic [NUM_REQ-1:0]        req_ready_s;
    logic                      hdr_valid_s;
    logic                      capture_s;
    logic                      hdr_fire_s;
    logic                      eop_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_WD   (REQ_ID_WD)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_r),
        .grant      (arb_grant_s),
        .grant_idx  (arb_idx_s),
        .any_req    (any_req_s)
    );

    assign capture_s  = (state_r == ST_IDLE) && any_req_s;
    assign hdr_fire_s = hdr_valid_s && hdr_ready;
    assign eop_s      = mon_valid && mon_ready && mon_last;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; EOP handshakes outside WAIT_EOP are ignored.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:     state_nxt_s = any_req_s  ? ST_OFFER    : ST_IDLE;
            ST_OFFER:    state_nxt_s = hdr_fire_s ? ST_WAIT_EOP : ST_OFFER;
            ST_WAIT_EOP: state_nxt_s = eop_s      ? ST_IDLE     : ST_WAIT_EOP;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs; the capture strobe is held off while reset is asserted.
    always_comb begin
        req_ready_s = '0;
        hdr_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rst_n) begin
                    req_ready_s = arb_grant_s;
                end else begin
                    req_ready_s = '0;
                end
            end
            ST_OFFER:    hdr_valid_s = 1'b1;
            ST_WAIT_EOP: hdr_valid_s = 1'b0;
            default: begin
                req_ready_s = '0;
                hdr_valid_s = 1'b0;
            end
        endcase
    end

    // Capture the winning header, update round-robin pointer and grant id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data_r  <= '0;
            hold_keep_r  <= '0;
            hold_cnt_r   <= '0;
            last_grant_r <= REQ_ID_WD'(NUM_REQ - 1);
            grant_id_r   <= '0;
        end else if (capture_s) begin
            hold_data_r  <= req_data[arb_idx_s*DATA_WD +: DATA_WD];
            hold_keep_r  <= req_keep[arb_idx_s*DATA_BYTE_WD +: DATA_BYTE_WD];
            hold_cnt_r   <= req_byte_cnt[arb_idx_s*BYTE_CNT_WD +: BYTE_CNT_WD];
            last_grant_r <= arb_idx_s;
            grant_id_r   <= arb_idx_s;
        end else begin
            hold_data_r  <= hold_data_r;
            hold_keep_r  <= hold_keep_r;
            hold_cnt_r   <= hold_cnt_r;
            last_grant_r <= last_grant_r;
            grant_id_r   <= grant_id_r;
        end
    end

    // Completed-packet counter, wrapping naturally at 2^PKT_CNT_WD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_r <= '0;
        end else if ((state_r == ST_WAIT_EOP) && eop_s) begin
            pkt_cnt_r <= pkt_cnt_r + PKT_CNT_WD'(1);
        end else begin
            pkt_cnt_r <= pkt_cnt_r;
        end
    end

    assign req_ready    = req_ready_s;
    assign hdr_valid    = hdr_valid_s;
    assign hdr_data     = hold_data_r;
    assign hdr_keep     = hold_keep_r;
    assign hdr_byte_cnt = hold_cnt_r;
    assign grant_id     = grant_id_r;
    assign busy         = (state_r != ST_IDLE);
    assign pkt_cnt      = pkt_cnt_r;

endmodule
